neural_stream_packer: RTL and testbench

Parametrised single-clock successor to the neural-data stream buffer. Packs `RATIO` consecutive `IN_W`-bit samples into one `IN_W*RATIO`-bit word and buffers the words in an internal synchronous FIFO of `DEPTH` words. Exposes a Xillybus-style read pipe with sticky overflow and overflow-signalling EOF. Sits between the acquisition sample stream and the host read pipe.

---
 rtl/neural_stream_pkg.sv | 14 +
 rtl/neural_stream_packer_fifo.sv | 65 ++++++
 rtl/neural_stream_packer.sv | 129 ++++++++++++
 tb/tb_neural_stream_packer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/neural_stream_pkg.sv
// Shared constants and width helpers for the neural sample stream packer.
package neural_stream_pkg;

    localparam int DROP_W = 32;

    function automatic int out_w(input int in_w, input int ratio);
        return in_w * ratio;
    endfunction

    function automatic int fill_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/neural_stream_packer_fifo.sv
// sync_fifo_wide: single-clock RAM FIFO with registered read data, word count
// and synchronous clear. Writes into a full FIFO are dropped.
module sync_fifo_wide #(
    parameter int W     = 32,
    parameter int DEPTH = 2048
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic                   i_wen,
    input  logic [W-1:0]           i_wdata,
    input  logic                   i_ren,
    output logic [W-1:0]           o_rdata,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_empty,
    output logic                   o_full
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [W-1:0]  r_rdata;
    logic          w_push;
    logic          w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign w_push  = i_wen & ~o_full;
    assign w_pop   = i_ren & ~o_empty;

    // Storage has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rdata  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_rdata  <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_rdata;
    assign o_count = r_count;

endmodule

// File: rtl/neural_stream_packer.sv
// Packs RATIO samples per word into a FIFO feeding a host read pipe with sticky
// overflow/EOF. Optional drop counter: define NEURAL_PACKER_DROP_COUNT_EN.
module neural_stream_packer
    import neural_stream_pkg::*;
#(
    parameter int IN_W      = 16,
    parameter int RATIO     = 2,
    parameter int DEPTH     = 2048,
    parameter int LSB_FIRST = 1
) (
    input  logic                               bus_clk,
    input  logic                               reset,
    input  logic [IN_W-1:0]                    in_data,
    input  logic                               in_wen,
    input  logic                               user_r_neural_data_open,
    input  logic                               user_r_neural_data_rden,
    output logic                               user_r_neural_data_empty,
    output logic                               user_r_neural_data_eof,
    output logic [out_w(IN_W, RATIO)-1:0]      user_r_neural_data_data,
    output logic                               overflow,
    output logic [fill_w(DEPTH)-1:0]           fill_level
`ifdef NEURAL_PACKER_DROP_COUNT_EN
    ,
    output logic [DROP_W-1:0]                  drop_count
`endif
);

    localparam int OUT_W  = out_w(IN_W, RATIO);
    localparam int FILL_W = fill_w(DEPTH);
    localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

    logic              w_lclr;
    logic              w_accept;
    logic              w_last;
    logic              w_push;
    logic              w_drop;
    logic              w_fifo_empty;
    logic              w_fifo_full;
    logic [OUT_W-1:0]  w_word;
    logic [FILL_W-1:0] w_count;
    logic [LANE_W-1:0] r_lane;
    logic [OUT_W-1:0]  r_word;
    logic              r_overflow;

    // Closing the pipe behaves exactly like reset, discarding any partial word.
    assign w_lclr   = reset | ~user_r_neural_data_open;
    assign w_accept = in_wen & ~r_overflow;
    assign w_last   = (r_lane == LAST_LANE);
    assign w_push   = w_accept & w_last;
    assign w_drop   = w_push & w_fifo_full;

    // The completed word includes the sample arriving this cycle, so the last
    // lane is pushed straight into the FIFO without an extra stage.
    genvar gi;
    generate
        for (gi = 0; gi < RATIO; gi++) begin : g_lane
            localparam int SAMPLE_IDX = (LSB_FIRST != 0) ? gi : (RATIO - 1 - gi);
            assign w_word[gi*IN_W +: IN_W] = (r_lane == LANE_W'(SAMPLE_IDX)) ?
                                             in_data : r_word[gi*IN_W +: IN_W];
        end
    endgenerate

    always_ff @(posedge bus_clk) begin
        if (w_lclr) begin
            r_lane     <= '0;
            r_word     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_word <= w_word;
                r_lane <= w_last ? '0 : r_lane + 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    sync_fifo_wide #(
        .W     (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (bus_clk),
        .srst    (w_lclr),
        .i_wen   (w_push),
        .i_wdata (w_word),
        .i_ren   (user_r_neural_data_rden),
        .o_rdata (user_r_neural_data_data),
        .o_count (w_count),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    assign user_r_neural_data_empty = w_fifo_empty;
    assign user_r_neural_data_eof   = r_overflow & w_fifo_empty;
    assign overflow                 = r_overflow;
    assign fill_level               = w_count;

`ifdef NEURAL_PACKER_DROP_COUNT_EN
    logic [DROP_W-1:0] r_drop_count;
    logic [DROP_W-1:0] w_drop_inc;
    logic [DROP_W:0]   w_drop_sum;

    // The overflow event loses a whole word; afterwards every strobe is one sample.
    always_comb begin
        w_drop_inc = '0;
        if (w_drop) begin
            w_drop_inc = DROP_W'(RATIO);
        end else if (in_wen && r_overflow) begin
            w_drop_inc = DROP_W'(1);
        end
        w_drop_sum = {1'b0, r_drop_count} + {1'b0, w_drop_inc};
    end

    always_ff @(posedge bus_clk) begin
        if (w_lclr) begin
            r_drop_count <= '0;
        end else if (w_drop_sum[DROP_W]) begin
            r_drop_count <= '1;
        end else begin
            r_drop_count <= w_drop_sum[DROP_W-1:0];
        end
    end

    assign drop_count = r_drop_count;
`endif

endmodule

// File: tb/tb_neural_stream_packer.sv
// Scoreboard bench: two packers (LSB-first and MSB-first, DEPTH=8) share one stimulus.
module tb_neural_stream_packer;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        open = 1'b1;
    logic [15:0] in_data = '0;
    logic        in_wen = 1'b0;
    logic        rden = 1'b0;

    logic        empty_a, eof_a, ovf_a, empty_b, eof_b, ovf_b;
    logic [31:0] data_a, data_b;
    logic [3:0]  fill_a, fill_b;
`ifdef NEURAL_PACKER_DROP_COUNT_EN
    logic [31:0] drop_a, drop_b;
`endif

    int total = 0;
    int bad = 0;

    logic [31:0] q_a[$];
    logic [31:0] q_b[$];
    logic [31:0] m_wa, m_wb, m_data_a, m_data_b;
    int          m_lane;
    logic        m_ovf;
    int          m_drop;

    always #5 clk = ~clk;

    neural_stream_packer #(.IN_W(16), .RATIO(2), .DEPTH(DEPTH), .LSB_FIRST(1)) dut_a (
        .bus_clk                  (clk),
        .reset                    (reset),
        .in_data                  (in_data),
        .in_wen                   (in_wen),
        .user_r_neural_data_open  (open),
        .user_r_neural_data_rden  (rden),
        .user_r_neural_data_empty (empty_a),
        .user_r_neural_data_eof   (eof_a),
        .user_r_neural_data_data  (data_a),
        .overflow                 (ovf_a),
        .fill_level               (fill_a)
`ifdef NEURAL_PACKER_DROP_COUNT_EN
        ,
        .drop_count               (drop_a)
`endif
    );

    neural_stream_packer #(.IN_W(16), .RATIO(2), .DEPTH(DEPTH), .LSB_FIRST(0)) dut_b (
        .bus_clk                  (clk),
        .reset                    (reset),
        .in_data                  (in_data),
        .in_wen                   (in_wen),
        .user_r_neural_data_open  (open),
        .user_r_neural_data_rden  (rden),
        .user_r_neural_data_empty (empty_b),
        .user_r_neural_data_eof   (eof_b),
        .user_r_neural_data_data  (data_b),
        .overflow                 (ovf_b),
        .fill_level               (fill_b)
`ifdef NEURAL_PACKER_DROP_COUNT_EN
        ,
        .drop_count               (drop_b)
`endif
    );

    // Drives one cycle starting at a negedge and advances the reference model
    // at the posedge; returns at the following negedge.
    task automatic do_cycle(input logic wen, input logic [15:0] d, input logic rd);
        bit pop;
        in_wen  = wen;
        in_data = d;
        rden    = rd;
        @(posedge clk);
        if (reset || !open) begin
            q_a.delete();
            q_b.delete();
            m_lane = 0; m_wa = '0; m_wb = '0; m_ovf = 1'b0;
            m_data_a = '0; m_data_b = '0; m_drop = 0;
        end else begin
            pop = rd && (q_a.size() > 0);
            if (wen) begin
                if (m_ovf) begin
                    m_drop++;
                end else begin
                    m_wa[m_lane*16 +: 16] = d;
                    m_wb[(1-m_lane)*16 +: 16] = d;
                    if (m_lane == 1) begin
                        if (q_a.size() == DEPTH) begin
                            m_ovf = 1'b1;
                            m_drop += 2;
                        end else begin
                            q_a.push_back(m_wa);
                            q_b.push_back(m_wb);
                        end
                        m_lane = 0;
                    end else begin
                        m_lane = 1;
                    end
                end
            end
            if (pop) begin
                m_data_a = q_a.pop_front();
                m_data_b = q_b.pop_front();
            end
        end
        @(negedge clk);
        in_wen = 1'b0;
        rden   = 1'b0;
    endtask

    task automatic reopen();
        open = 1'b0;
        do_cycle(1'b0, 16'h0, 1'b0);
        open = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        do_cycle(1'b0, 16'h0, 1'b0);
        do_cycle(1'b1, 16'h5555, 1'b1);
        reset = 1'b0;
        total += 6;
        if (empty_a !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", empty_a); end
        if (eof_a !== 1'b0) begin bad++; $display("FAIL reset_eof got=%b want=0", eof_a); end
        if (ovf_a !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", ovf_a); end
        if (fill_a !== 4'd0) begin bad++; $display("FAIL reset_fill got=%0d want=0", fill_a); end
        if (data_a !== 32'h0) begin bad++; $display("FAIL reset_data_a got=%h want=0", data_a); end
        if (data_b !== 32'h0) begin bad++; $display("FAIL reset_data_b got=%h want=0", data_b); end
    endtask

    task automatic test_packing();
        do_cycle(1'b1, 16'h1111, 1'b0);
        total += 1;
        if (empty_a !== 1'b1) begin bad++; $display("FAIL half_word_empty got=%b want=1", empty_a); end
        do_cycle(1'b1, 16'h2222, 1'b0);
        total += 2;
        if (empty_a !== 1'b0) begin bad++; $display("FAIL word_empty got=%b want=0", empty_a); end
        if (fill_a !== 4'(q_a.size())) begin bad++; $display("FAIL word_fill got=%0d want=%0d", fill_a, q_a.size()); end
        do_cycle(1'b0, 16'h0, 1'b1);
        total += 4;
        if (data_a !== m_data_a) begin bad++; $display("FAIL lsb_first_data got=%h want=%h", data_a, m_data_a); end
        if (data_b !== m_data_b) begin bad++; $display("FAIL msb_first_data got=%h want=%h", data_b, m_data_b); end
        if (empty_a !== 1'b1) begin bad++; $display("FAIL read_empty got=%b want=1", empty_a); end
        if (empty_b !== 1'b1) begin bad++; $display("FAIL read_empty_b got=%b want=1", empty_b); end
        do_cycle(1'b0, 16'h0, 1'b1);
        total += 1;
        if (data_a !== m_data_a) begin bad++; $display("FAIL empty_read_hold got=%h want=%h", data_a, m_data_a); end
    endtask

    task automatic test_overflow();
        reopen();
        for (int i = 0; i < 18; i++) begin
            do_cycle(1'b1, 16'(16'h0100 + i), 1'b0);
            if (i == 16) begin
                total += 2;
                if (ovf_a !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b want=0", ovf_a); end
                if (fill_a !== 4'd8) begin bad++; $display("FAIL fill_full got=%0d want=8", fill_a); end
            end
        end
        total += 4;
        if (ovf_a !== m_ovf) begin bad++; $display("FAIL ovf_set got=%b want=%b", ovf_a, m_ovf); end
        if (ovf_b !== m_ovf) begin bad++; $display("FAIL ovf_set_b got=%b want=%b", ovf_b, m_ovf); end
        if (fill_a !== 4'd8) begin bad++; $display("FAIL fill_after_ovf got=%0d want=8", fill_a); end
        if (eof_a !== 1'b0) begin bad++; $display("FAIL eof_before_drain got=%b want=0", eof_a); end
        for (int i = 0; i < DEPTH; i++) begin
            do_cycle(1'b1, 16'hDEAD, 1'b1);
            total += 2;
            if (data_a !== m_data_a) begin bad++; $display("FAIL drain_a[%0d] got=%h want=%h", i, data_a, m_data_a); end
            if (data_b !== m_data_b) begin bad++; $display("FAIL drain_b[%0d] got=%h want=%h", i, data_b, m_data_b); end
        end
        total += 4;
        if (empty_a !== 1'b1) begin bad++; $display("FAIL drained_empty got=%b want=1", empty_a); end
        if (eof_a !== 1'b1) begin bad++; $display("FAIL drained_eof got=%b want=1", eof_a); end
        if (eof_b !== 1'b1) begin bad++; $display("FAIL drained_eof_b got=%b want=1", eof_b); end
        if (fill_a !== 4'd0) begin bad++; $display("FAIL drained_fill got=%0d want=0", fill_a); end
    endtask

    task automatic test_full_push_pop();
        reopen();
        total += 2;
        if (ovf_a !== 1'b0) begin bad++; $display("FAIL reopen_ovf got=%b want=0", ovf_a); end
        if (eof_a !== 1'b0) begin bad++; $display("FAIL reopen_eof got=%b want=0", eof_a); end
        for (int i = 0; i < 17; i++) do_cycle(1'b1, 16'(16'h3000 + i), 1'b0);
        do_cycle(1'b1, 16'h3011, 1'b1);
        total += 4;
        if (ovf_a !== 1'b1) begin bad++; $display("FAIL pushpop_ovf got=%b want=1", ovf_a); end
        if (data_a !== m_data_a) begin bad++; $display("FAIL pushpop_data got=%h want=%h", data_a, m_data_a); end
        if (fill_a !== 4'(q_a.size())) begin bad++; $display("FAIL pushpop_fill got=%0d want=%0d", fill_a, q_a.size()); end
        if (eof_a !== 1'b0) begin bad++; $display("FAIL pushpop_eof got=%b want=0", eof_a); end
    endtask

    task automatic test_close_midword();
        reopen();
        do_cycle(1'b1, 16'h1234, 1'b0);
        reopen();
        total += 3;
        if (fill_a !== 4'd0) begin bad++; $display("FAIL midword_fill got=%0d want=0", fill_a); end
        if (ovf_a !== 1'b0) begin bad++; $display("FAIL midword_ovf got=%b want=0", ovf_a); end
        if (data_a !== 32'h0) begin bad++; $display("FAIL midword_data got=%h want=0", data_a); end
        do_cycle(1'b1, 16'hAAAA, 1'b0);
        do_cycle(1'b1, 16'hBBBB, 1'b0);
        do_cycle(1'b0, 16'h0, 1'b1);
        total += 2;
        if (data_a !== m_data_a) begin bad++; $display("FAIL midword_word got=%h want=%h", data_a, m_data_a); end
        if (data_b !== m_data_b) begin bad++; $display("FAIL midword_word_b got=%h want=%h", data_b, m_data_b); end
    endtask

    task automatic test_back_to_back();
        reopen();
        do_cycle(1'b1, 16'h4000, 1'b0);
        for (int i = 1; i < 12; i++) begin
            do_cycle(1'b1, 16'(16'h4000 + i), 1'b1);
            total += 2;
            if (data_a !== m_data_a) begin bad++; $display("FAIL b2b_data[%0d] got=%h want=%h", i, data_a, m_data_a); end
            if (fill_a !== 4'(q_a.size())) begin bad++; $display("FAIL b2b_fill[%0d] got=%0d want=%0d", i, fill_a, q_a.size()); end
        end
    endtask

`ifdef NEURAL_PACKER_DROP_COUNT_EN
    task automatic test_drop_count();
        reopen();
        for (int i = 0; i < 21; i++) do_cycle(1'b1, 16'(16'h5000 + i), 1'b0);
        total += 2;
        if (drop_a !== 32'(m_drop)) begin bad++; $display("FAIL drop_count got=%0d want=%0d", drop_a, m_drop); end
        if (drop_b !== 32'd5) begin bad++; $display("FAIL drop_count_b got=%0d want=5", drop_b); end
        reopen();
        total += 1;
        if (drop_a !== 32'd0) begin bad++; $display("FAIL drop_clear got=%0d want=0", drop_a); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_packing();
        test_overflow();
        test_full_push_pop();
        test_close_midword();
        test_back_to_back();
`ifdef NEURAL_PACKER_DROP_COUNT_EN
        test_drop_count();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
